// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, FSM state type and opcode legality check shared by the issuer
package alu_seq_pkg;
  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_MUL = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b0101;
  localparam logic [3:0] OP_MOD = 4'b0110;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETTLE = 2'd1, S_RESP = 2'd2} state_e;
  function automatic logic is_legal_op(input logic [3:0] op);
    return op >= OP_ADD && op <= OP_MOD;
  endfunction
endpackage

// File: rtl/alu_seq_timer.sv
// alu_seq_timer: loadable down-counter; done_o is high while the count is zero
// Ports: clk_i, rst_ni (async, active-low), load_i/val_i load a start count, done_o.
module alu_seq_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [3:0] val_i,
  output logic       done_o
);
  logic [3:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : (cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
  assign done_o = cnt_q == 4'd0;
endmodule

// File: rtl/alu_seq_issuer.sv
// alu_seq_issuer: issues one command at a time to the combinational ALU breadboard and returns its result
// Ports: cmd_* valid/ready command in; alu_* drive/sample the breadboard; rsp_* valid/ready response out;
// cnt_ops_o counts delivered responses. Macro ALU_SEQ_CHAIN_EN adds an accumulator that cmd_chain_i
// can select as operand 1; without it cmd_chain_i is ignored.
module alu_seq_issuer
  import alu_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [3:0]  cmd_op_i,
  input  logic [15:0] cmd_a_i,
  input  logic [15:0] cmd_b_i,
  input  logic        cmd_chain_i,
  output logic [15:0] alu_in1_o,
  output logic [15:0] alu_in2_o,
  output logic [3:0]  alu_op_o,
  input  logic [31:0] alu_out_i,
  input  logic [1:0]  alu_err_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic [1:0]  rsp_err_o,
  output logic        rsp_illegal_o,
  output logic [15:0] cnt_ops_o
);
  state_e      state_q, state_d;
  logic        rdy_q, rdy_d, vld_q, vld_d, ill_q, ill_d;
  logic [15:0] in1_q, in1_d, in2_q, in2_d, cnt_q, cnt_d, in1_sel;
  logic [3:0]  op_q, op_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  err_q, err_d, merr;
  logic        accept, legal, issue, capture, hs, done;
`ifdef ALU_SEQ_CHAIN_EN
  logic [15:0] acc_q, acc_d;
  assign in1_sel = cmd_chain_i ? acc_q : cmd_a_i;
  always_comb acc_d = capture && merr == 2'b00 ? alu_out_i[15:0] : acc_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) acc_q <= 16'd0;
    else acc_q <= acc_d;
`else
  logic unused_chain;
  assign unused_chain = cmd_chain_i;
  assign in1_sel = cmd_a_i;
`endif
  alu_seq_timer u_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (issue),
    .val_i  (4'(SETTLE_CYCLES - 1)),
    .done_o (done)
  );
  // accept/capture/hs are mutually exclusive: each is only possible in one state
  always_comb begin
    accept  = cmd_valid_i & rdy_q;
    legal   = is_legal_op(cmd_op_i);
    issue   = accept & legal;
    capture = state_q == S_SETTLE && done;
    hs      = vld_q & rsp_ready_i;
    // the breadboard reports ERR for every opcode; keep only flags meaningful for the op issued
    merr    = {alu_err_i[1] & (op_q == OP_DIV || op_q == OP_MOD),
               alu_err_i[0] & (op_q == OP_ADD || op_q == OP_SUB)};
    state_d = accept ? (legal ? S_SETTLE : S_RESP) : capture ? S_RESP : hs ? S_IDLE : state_q;
    // registered so ready stays low during reset and rises one edge after release
    rdy_d   = state_d == S_IDLE;
    in1_d   = issue ? in1_sel : in1_q;
    in2_d   = issue ? cmd_b_i : in2_q;
    op_d    = issue ? cmd_op_i : hs ? OP_NOP : op_q;
    vld_d   = (accept & ~legal) | capture ? 1'b1 : hs ? 1'b0 : vld_q;
    data_d  = capture ? alu_out_i : (accept | hs) ? 32'd0 : data_q;
    err_d   = capture ? merr : (accept | hs) ? 2'b00 : err_q;
    ill_d   = accept ? ~legal : hs ? 1'b0 : ill_q;
    cnt_d   = cnt_q + 16'(hs);
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b0;
      in1_q   <= 16'd0;
      in2_q   <= 16'd0;
      op_q    <= OP_NOP;
      vld_q   <= 1'b0;
      data_q  <= 32'd0;
      err_q   <= 2'b00;
      ill_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      op_q    <= op_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      err_q   <= err_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  assign cmd_ready_o   = rdy_q;
  assign alu_in1_o     = in1_q;
  assign alu_in2_o     = in2_q;
  assign alu_op_o      = op_q;
  assign rsp_valid_o   = vld_q;
  assign rsp_data_o    = data_q;
  assign rsp_err_o     = err_q;
  assign rsp_illegal_o = ill_q;
  assign cnt_ops_o     = cnt_q;
endmodule

// File: tb/tb_alu_seq_issuer.sv
// tb_alu_seq_issuer: scoreboard bench for alu_seq_issuer with a behavioural breadboard attached
module tb_alu_seq_issuer;
  import alu_seq_pkg::*;
  localparam int S = 2;
  logic clk = 0, rst_n = 0, cmd_valid = 0, cmd_chain = 0, rsp_ready = 1;
  logic cmd_ready, rsp_valid, rsp_ill;
  logic [3:0] cmd_op = 0, alu_op;
  logic [15:0] cmd_a = 0, cmd_b = 0, alu_in1, alu_in2, cnt_ops;
  logic [31:0] alu_out, rsp_data;
  logic [1:0] alu_err, rsp_err, bb_err, force_err = 0;
  int vectors = 0, miscompares = 0, cyc = 0, exp_cnt = 0;
  typedef struct {logic [31:0] d; logic [1:0] e; logic i;} exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_seq_issuer #(.SETTLE_CYCLES(S)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b), .cmd_chain_i(cmd_chain),
    .alu_in1_o(alu_in1), .alu_in2_o(alu_in2), .alu_op_o(alu_op),
    .alu_out_i(alu_out), .alu_err_i(alu_err),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .rsp_illegal_o(rsp_ill), .cnt_ops_o(cnt_ops)
  );

  // breadboard model: reports ERR for every opcode, garbage on unused channels
  always_comb begin
    bb_err = 2'b00;
    alu_out = 32'hDEAD_BEEF;
    case (alu_op)
      OP_ADD: begin alu_out = 32'(alu_in1) + 32'(alu_in2); bb_err[0] = alu_out[16]; end
      OP_SUB: begin alu_out = 32'(alu_in1) - 32'(alu_in2); bb_err[0] = alu_in2 > alu_in1; end
      OP_MUL: alu_out = 32'(alu_in1) * 32'(alu_in2);
      OP_DIV: if (alu_in2 == 0) begin alu_out = 0; bb_err[1] = 1'b1; end else alu_out = 32'(alu_in1 / alu_in2);
      OP_MOD: if (alu_in2 == 0) begin alu_out = 0; bb_err[1] = 1'b1; end else alu_out = 32'(alu_in1 % alu_in2);
      default: ;
    endcase
  end
  assign alu_err = bb_err | force_err;

  // scoreboard: pop and compare on every response handshake
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && rsp_valid && rsp_ready) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_rsp: got data=%0h err=%b ill=%b, required no response", rsp_data, rsp_err, rsp_ill);
      end else begin
        e = q.pop_front();
        if ({rsp_data, rsp_err, rsp_ill} !== {e.d, e.e, e.i}) begin
          miscompares++;
          $display("FAIL rsp: got data=%0d err=%b ill=%b, required data=%0d err=%b ill=%b",
                   rsp_data, rsp_err, rsp_ill, e.d, e.e, e.i);
        end
      end
    end
  end

  task automatic issue(input logic [3:0] op, input logic [15:0] a, b, input logic ch,
                       input logic [31:0] ed, input logic [1:0] ee, input logic ei,
                       output int lat, output logic [3:0] op1, output logic [15:0] in1,
                       output logic nz, output int acc_cyc);
    exp_t e;
    int w = 0;
    while (!cmd_ready && w < 100) begin @(negedge clk); w++; end
    if (!cmd_ready) begin
      vectors++; miscompares++;
      $display("FAIL issue_timeout: cmd_ready=0, required 1");
    end
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = ch; cmd_valid = 1;
    e.d = ed; e.e = ee; e.i = ei; q.push_back(e);
    acc_cyc = cyc; lat = 0; nz = 0; op1 = 0; in1 = 0;
    do begin
      @(negedge clk);
      lat++;
      cmd_valid = 0;
      if (lat == 1) begin op1 = alu_op; in1 = alu_in1; end
      nz |= (alu_op != OP_NOP);
    end while (!rsp_valid && lat < 100);
  endtask

  task automatic test_reset();
    logic seen = 0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({cmd_ready, rsp_valid, alu_op, alu_in1, alu_in2, rsp_data, rsp_err, rsp_ill, cnt_ops} !== '0) begin
      miscompares++; $display("FAIL reset_outputs: ready=%b op=%h data=%h cnt=%h, required all 0", cmd_ready, alu_op, rsp_data, cnt_ops);
    end
    rst_n = 1;
    #1;
    vectors++;
    if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL ready_at_release: got %b required 0", cmd_ready); end
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_release: got %b required 1", cmd_ready); end
    cmd_op = OP_ADD; cmd_a = 16'd1; cmd_b = 16'd2; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    vectors++;
    if ({alu_op, alu_in1} !== {OP_ADD, 16'd1}) begin miscompares++; $display("FAIL abort_issue: op=%h in1=%0d required op=2 in1=1", alu_op, alu_in1); end
    rst_n = 0;
    #1;
    vectors++;
    if ({cmd_ready, rsp_valid, alu_op, alu_in1, alu_in2, rsp_data, rsp_err, rsp_ill, cnt_ops} !== '0) begin
      miscompares++; $display("FAIL abort_outputs: ready=%b op=%h in1=%0d valid=%b, required all 0", cmd_ready, alu_op, alu_in1, rsp_valid);
    end
    @(negedge clk);
    rst_n = 1;
    repeat (6) begin @(negedge clk); seen |= rsp_valid; end
    vectors++;
    if ({seen, cnt_ops, cmd_ready} !== {1'b0, 16'd0, 1'b1}) begin
      miscompares++; $display("FAIL abort_no_rsp: seen=%b cnt=%0d ready=%b, required 0 0 1", seen, cnt_ops, cmd_ready);
    end
  endtask

  task automatic test_add();
    int lat, ac; logic [3:0] op1; logic [15:0] in1; logic nz;
    issue(OP_ADD, 16'd11, 16'd51, 0, 32'd62, 2'b00, 0, lat, op1, in1, nz, ac);
    vectors++;
    if (lat !== S + 1) begin miscompares++; $display("FAIL add_latency: got %0d required %0d", lat, S + 1); end
    vectors++;
    if (op1 !== OP_ADD) begin miscompares++; $display("FAIL add_alu_op: got %b required 0010", op1); end
    @(negedge clk);
    exp_cnt++;
    vectors++;
    if ({cnt_ops, alu_op, rsp_valid, rsp_data} !== {16'(exp_cnt), OP_NOP, 1'b0, 32'd0}) begin
      miscompares++; $display("FAIL add_after_hs: cnt=%0d op=%b valid=%b data=%0d, required cnt=%0d op=0000 valid=0 data=0", cnt_ops, alu_op, rsp_valid, rsp_data, exp_cnt);
    end
    issue(OP_ADD, 16'd40000, 16'd30000, 0, 32'd70000, 2'b01, 0, lat, op1, in1, nz, ac);
    @(negedge clk);
    exp_cnt++;
  endtask

  task automatic test_errors();
    int lat, ac; logic [3:0] op1; logic [15:0] in1; logic nz;
    issue(OP_DIV, 16'd11, 16'd0, 0, 32'd0, 2'b10, 0, lat, op1, in1, nz, ac);
    @(negedge clk); exp_cnt++;
    force_err = 2'b01;
    issue(OP_MUL, 16'd3, 16'd4, 0, 32'd12, 2'b00, 0, lat, op1, in1, nz, ac);
    @(negedge clk); exp_cnt++;
    issue(OP_MOD, 16'd17, 16'd5, 0, 32'd2, 2'b00, 0, lat, op1, in1, nz, ac);
    @(negedge clk); exp_cnt++;
    force_err = 2'b10;
    issue(OP_ADD, 16'd1, 16'd1, 0, 32'd2, 2'b00, 0, lat, op1, in1, nz, ac);
    @(negedge clk); exp_cnt++;
    force_err = 2'b00;
    vectors++;
    if (cnt_ops !== 16'(exp_cnt)) begin miscompares++; $display("FAIL err_cnt: got %0d required %0d", cnt_ops, exp_cnt); end
  endtask

  task automatic test_illegal();
    int lat, ac; logic [3:0] op1; logic [15:0] in1; logic nz;
    issue(4'b1000, 16'd7, 16'd9, 0, 32'd0, 2'b00, 1, lat, op1, in1, nz, ac);
    vectors++;
    if (lat !== 1) begin miscompares++; $display("FAIL illegal_latency: got %0d required 1", lat); end
    vectors++;
    if (nz !== 1'b0) begin miscompares++; $display("FAIL illegal_alu_op: op left 0000, required to stay 0000"); end
    @(negedge clk);
    exp_cnt++;
    vectors++;
    if ({cnt_ops, rsp_ill} !== {16'(exp_cnt), 1'b0}) begin miscompares++; $display("FAIL illegal_hs: cnt=%0d ill=%b required %0d 0", cnt_ops, rsp_ill, exp_cnt); end
  endtask

  task automatic test_backpressure();
    int lat, ac; logic [3:0] op1; logic [15:0] in1; logic nz;
    rsp_ready = 0;
    issue(OP_SUB, 16'd100, 16'd30, 0, 32'd70, 2'b00, 0, lat, op1, in1, nz, ac);
    repeat (5) begin
      vectors++;
      if ({rsp_valid, rsp_data, cmd_ready, alu_op, cnt_ops} !== {1'b1, 32'd70, 1'b0, OP_SUB, 16'(exp_cnt)}) begin
        miscompares++; $display("FAIL bp_hold: valid=%b data=%0d ready=%b op=%b cnt=%0d, required 1 70 0 0011 %0d", rsp_valid, rsp_data, cmd_ready, alu_op, cnt_ops, exp_cnt);
      end
      @(negedge clk);
    end
    rsp_ready = 1;
    #1;
    vectors++;
    if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL bp_hs_ready: got %b required 0", cmd_ready); end
    @(negedge clk);
    exp_cnt++;
    vectors++;
    if ({cnt_ops, rsp_valid, rsp_data, alu_op, cmd_ready} !== {16'(exp_cnt), 1'b0, 32'd0, OP_NOP, 1'b1}) begin
      miscompares++; $display("FAIL bp_release: cnt=%0d valid=%b data=%0d op=%b ready=%b, required %0d 0 0 0000 1", cnt_ops, rsp_valid, rsp_data, alu_op, cmd_ready, exp_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int lat, a1, a2; logic [3:0] op1; logic [15:0] in1; logic nz;
    issue(OP_MUL, 16'd300, 16'd300, 0, 32'd90000, 2'b00, 0, lat, op1, in1, nz, a1);
    issue(OP_SUB, 16'd9, 16'd4, 0, 32'd5, 2'b00, 0, lat, op1, in1, nz, a2);
    vectors++;
    if (a2 - a1 !== S + 2) begin miscompares++; $display("FAIL issue_interval: got %0d required %0d", a2 - a1, S + 2); end
    @(negedge clk);
    exp_cnt += 2;
    vectors++;
    if (cnt_ops !== 16'(exp_cnt)) begin miscompares++; $display("FAIL b2b_cnt: got %0d required %0d", cnt_ops, exp_cnt); end
  endtask

  task automatic test_chain();
    int lat, ac; logic [3:0] op1; logic [15:0] in1; logic nz;
`ifdef ALU_SEQ_CHAIN_EN
    issue(OP_MUL, 16'd3, 16'd4, 0, 32'd12, 2'b00, 0, lat, op1, in1, nz, ac);
    @(negedge clk); exp_cnt++;
    issue(OP_ADD, 16'd99, 16'd5, 1, 32'd17, 2'b00, 0, lat, op1, in1, nz, ac);
    vectors++;
    if (in1 !== 16'd12) begin miscompares++; $display("FAIL chain_in1: got %0d required 12", in1); end
`else
    issue(OP_ADD, 16'd99, 16'd5, 1, 32'd104, 2'b00, 0, lat, op1, in1, nz, ac);
    vectors++;
    if (in1 !== 16'd99) begin miscompares++; $display("FAIL chain_in1: got %0d required 99", in1); end
`endif
    @(negedge clk); exp_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_errors();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_chain();
    repeat (3) @(negedge clk);
    vectors++;
    if (q.size() !== 0) begin miscompares++; $display("FAIL scoreboard_drain: %0d left, required 0", q.size()); end
    vectors++;
    if (cnt_ops !== 16'(exp_cnt)) begin miscompares++; $display("FAIL final_cnt: got %0d required %0d", cnt_ops, exp_cnt); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_seq_issuer.md
# alu_seq_issuer

Sequential front-end that issues operations to the arithmetic breadboard and returns its results. Accepts one command at a time on a valid/ready handshake and drives the breadboard's IN1/IN2/OP inputs from registers. It waits a fixed settle interval, then captures OUT/ERR and presents them on a valid/ready response port. It sits between the datapath controller and the combinational ALU breadboard, making that block usable from clocked logic.

## Interface
- SETTLE_CYCLES, 2: clock cycles ALU inputs are held before capture; legal range 1..15.
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  issuer can accept a command.
- CMD_OP  in  4  opcode: 0010 add, 0011 sub, 0100 mul, 0101 div, 0110 mod.
- CMD_A  in  16  operand 1.
- CMD_B  in  16  operand 2.
- CMD_CHAIN  in  1  use accumulator as operand 1; only honoured with ALU_SEQ_CHAIN_EN.
- ALU_IN1  out  16  to breadboard IN1.
- ALU_IN2  out  16  to breadboard IN2.
- ALU_OP  out  4  to breadboard OP; 0000 (ground channel) when not issuing.
- ALU_OUT  in  32  from breadboard OUT.
- ALU_ERR  in  2  from breadboard ERR: [1] divide/mod by zero, [0] overflow.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  consumer takes response.
- RSP_DATA  out  32  captured result.
- RSP_ERR  out  2  masked error flags.
- RSP_ILLEGAL  out  1  opcode was outside 0010..0110.
- CNT_OPS  out  16  count of delivered responses.

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE: CMD_READY=1 and ALU_OP=0000. On CMD_VALID&CMD_READY, latch the operands and opcode.
  - Legal opcode: go to SETTLE. Load the settle counter with SETTLE_CYCLES-1 and drive the ALU_* registers.
  - Illegal opcode: go straight to RESP with RSP_DATA=0, RSP_ERR=00 and RSP_ILLEGAL=1. ALU_OP stays 0000.
- SETTLE: CMD_READY=0 and ALU_* are held constant. The counter decrements each cycle. At count 0, capture ALU_OUT into RSP_DATA and masked ALU_ERR into RSP_ERR, then go to RESP.
- Error masking:
  - RSP_ERR[0] = ALU_ERR[0] only for add/sub.
  - RSP_ERR[1] = ALU_ERR[1] only for div/mod.
  - Both are 0 otherwise, because the breadboard drives ERR for every opcode.
- RESP: RSP_VALID=1. RSP_DATA, RSP_ERR and RSP_ILLEGAL are stable until RSP_VALID&RSP_READY. On that handshake: CNT_OPS increments, state returns to IDLE, ALU_OP returns to 0000, RSP_* clear to 0.
- CNT_OPS wraps from FFFF to 0000.
- No new command is accepted in the cycle a response handshake completes.

## Timing
- Reset (async assert, sync deassert at the flop level): state IDLE, all outputs 0 except CMD_READY. CMD_READY is 0 while RST_N is low and 1 on the first clock after release.
- Reset mid-operation aborts the in-flight command. No response is produced and CNT_OPS is not incremented.
- Latency:
  - Accept edge to RSP_VALID rise is SETTLE_CYCLES+1 edges for a legal opcode and 1 edge for an illegal one.
  - ALU_* change on the edge after accept.
- Minimum issue interval: SETTLE_CYCLES+2 cycles when RSP_READY is held high.
- Backpressure: RSP_READY may stay low indefinitely. Outputs hold, CMD_READY stays 0, and ALU_* hold their values.

## Configuration
- ALU_SEQ_CHAIN_EN defined:
  - A 16-bit accumulator ACC (reset 0) is loaded with RSP_DATA[15:0] on every capture where RSP_ERR=00 and RSP_ILLEGAL=0.
  - A command with CMD_CHAIN=1 drives ACC onto ALU_IN1 instead of CMD_A.
- ALU_SEQ_CHAIN_EN undefined: CMD_CHAIN is ignored (port retained), no ACC register exists, and ALU_IN1 is always CMD_A.

## Structure
- Package alu_seq_pkg holds:
  - opcode localparams OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD, OP_NOP=4'b0000;
  - the state enum typedef;
  - an is_legal_op function.
- One sub-module, alu_seq_timer: a loadable down-counter with done flag that implements SETTLE.

## Test plan
- Reset: pulse RST_N low mid-SETTLE, with ALU driven -> all outputs 0 immediately, no response, CNT_OPS=0, CMD_READY=1 one edge after release.
- ADD 11+51, SETTLE_CYCLES=2, breadboard model attached -> ALU_OP=0010, RSP_VALID 3 edges after accept, RSP_DATA=62, RSP_ERR=00.
- DIV 11/0 -> RSP_DATA=0, RSP_ERR=10. MUL while ALU_ERR[0]=1 -> RSP_ERR=00 (masking).
- Illegal opcode 1000 -> RSP_VALID 1 edge after accept, RSP_ILLEGAL=1, ALU_OP never leaves 0000.
- Backpressure: RSP_READY low for 5 cycles -> RSP_DATA stable, CMD_READY=0, CNT_OPS increments only on the handshake edge.
- Chain (macro on): MUL 3*4 -> 12, then ADD with CHAIN=1, B=5 -> ALU_IN1=12, RSP_DATA=17. Macro off -> ALU_IN1=CMD_A.
